// File: rtl/convertidor_8_32_pkg.sv
// Shared definitions for the 8<->32 lane converters (packer and serializer).
// Width codes, lane/word widths and per-mode helpers.
package convertidor_8_32_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 32;

  typedef enum logic [1:0] {
    W32  = 2'b00,
    W16  = 2'b01,
    W8   = 2'b10,
    WRSV = 2'b11
  } width_e;

  // Bytes that make up one word in the given mode; reserved behaves as 8b.
  function automatic logic [2:0] bytes_per_mode(width_e m);
    case (m)
      W32:     bytes_per_mode = 3'd4;
      W16:     bytes_per_mode = 3'd2;
      default: bytes_per_mode = 3'd1;
    endcase
  endfunction

  // Keeps only the bytes belonging to the current word so stale bytes left
  // in the shift register never leak into the upper lanes.
  function automatic logic [OUT_W-1:0] width_mask(width_e m);
    case (m)
      W32:     width_mask = 32'hFFFF_FFFF;
      W16:     width_mask = 32'h0000_FFFF;
      default: width_mask = 32'h0000_00FF;
    endcase
  endfunction

endpackage

// File: rtl/convertidor_8_32_cnt_bytes.sv
// Byte counter for the receive packer. Counts accepted bytes within a word
// and flags the byte that completes it, given the mode in effect.
module convertidor_cnt_bytes
  import convertidor_8_32_pkg::*;
(
  input  logic       clk,
  input  logic       reset_L,
  input  logic       clr,
  input  logic       acc,
  input  logic [1:0] mode,
  output logic [1:0] cnt,
  output logic       last
);

  logic [2:0] n;

  assign n    = bytes_per_mode(width_e'(mode));
  assign last = acc && ({1'b0, cnt} == (n - 3'd1));

  // Advance on each accepted byte, wrap to zero on the terminal byte.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  cnt <= 2'd0;
    else if (clr)  cnt <= 2'd0;
    else if (acc)  cnt <= last ? 2'd0 : cnt + 2'd1;
  end

endmodule

// File: rtl/convertidor_8_32.sv
// Receive-side byte packer: rebuilds 32/16/8-bit words from an MSB-first
// byte lane. Mode is taken from PCLK on the first byte of each word.
// Optional sticky error output enabled by defining CONVERTIDOR_ERR_EN.
module convertidor_8_32
  import convertidor_8_32_pkg::*;
#(
  parameter int IN_W  = convertidor_8_32_pkg::IN_W,
  parameter int OUT_W = convertidor_8_32_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             ENB,
  input  logic [1:0]       PCLK,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  in_8,
  output logic [OUT_W-1:0] out_32,
`ifdef CONVERTIDOR_ERR_EN
  output logic             err,
`endif
  output logic             valid_out
);

  logic             acc;
  logic             last;
  logic [1:0]       cnt;
  width_e           mode_q;
  width_e           eff_mode;
  logic [OUT_W-1:0] shreg;
  logic [OUT_W-1:0] word_next;

  assign acc       = ENB && valid_in;
  // On the first byte the live PCLK decides the word size; after that the
  // latched copy rules so mid-word PCLK changes are ignored.
  assign eff_mode  = (cnt == 2'd0) ? width_e'(PCLK) : mode_q;
  assign word_next = {shreg[OUT_W-IN_W-1:0], in_8};

  convertidor_cnt_bytes u_cnt (
    .clk     (clk),
    .reset_L (reset_L),
    .clr     (!ENB),
    .acc     (acc),
    .mode    (eff_mode),
    .cnt     (cnt),
    .last    (last)
  );

  // Latch the word width on the first accepted byte of each word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                  mode_q <= W8;
    else if (acc && cnt == 2'd0)   mode_q <= eff_mode;
  end

  // Shift accepted bytes in from the bottom; disable drops any partial word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  shreg <= '0;
    else if (!ENB) shreg <= '0;
    else if (acc)  shreg <= word_next;
  end

  // Publish the completed word and pulse valid_out the following cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_32    <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= last;
      if (last) out_32 <= word_next & width_mask(eff_mode);
    end
  end

`ifdef CONVERTIDOR_ERR_EN
  // Sticky flag for reserved widths or width changes inside a word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  err <= 1'b0;
    else if (!ENB) err <= 1'b0;
    else if (acc && (width_e'(PCLK) == WRSV ||
                     (cnt != 2'd0 && width_e'(PCLK) != mode_q)))
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_convertidor_8_32.sv
// Bench for convertidor_8_32: arithmetic reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_convertidor_8_32;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        ENB = 1'b0;
  logic [1:0]  PCLK = 2'b00;
  logic        valid_in = 1'b0;
  logic [7:0]  in_8 = 8'h00;
  logic [31:0] out_32;
  logic        valid_out;
`ifdef CONVERTIDOR_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int passed = 0;

  convertidor_8_32 dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .ENB       (ENB),
    .PCLK      (PCLK),
    .valid_in  (valid_in),
    .in_8      (in_8),
    .out_32    (out_32),
`ifdef CONVERTIDOR_ERR_EN
    .err       (err),
`endif
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: count bytes toward the word size chosen at the first
  // byte, accumulate numerically, emit when the count is reached.
  int          m_cnt, m_n;
  longint      m_word;
  logic [31:0] m_out;
  logic        m_vld;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_cnt = 0; m_n = 1; m_word = 0; m_out = 0; m_vld = 0;
    end else if (!ENB) begin
      m_cnt = 0; m_word = 0; m_vld = 0;
    end else if (valid_in) begin
      if (m_cnt == 0) m_n = (PCLK == 2'b00) ? 4 : (PCLK == 2'b01) ? 2 : 1;
      m_word = m_word * 256 + longint'(in_8);
      m_cnt++;
      if (m_cnt == m_n) begin
        m_out = 32'(m_word); m_vld = 1; m_cnt = 0; m_word = 0;
      end else m_vld = 0;
    end else m_vld = 0;
  end

  // Per-cycle comparison on the falling edge, and a log of emitted words.
  logic [31:0] pulses[$];
  always @(negedge clk) begin
    chk("cyc_valid", {31'b0, valid_out}, {31'b0, m_vld});
    chk("cyc_out", out_32, m_out);
    if (valid_out) pulses.push_back(out_32);
  end

  task automatic cyc(input logic v, input logic [7:0] b);
    valid_in = v; in_8 = b;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic chk_pulses(input string name, input logic [31:0] exp[$]);
    chk({name, "_count"}, 32'(pulses.size()), 32'(exp.size()));
    foreach (exp[i])
      if (i < pulses.size()) chk({name, "_word"}, pulses[i], exp[i]);
    pulses.delete();
  endtask

  initial begin
    logic [31:0] e[$];
    #2;
    chk("rst_out", out_32, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    #20 reset_L = 1'b1;
    @(posedge clk); #1;
    ENB = 1'b1;
    pulses.delete();

    // 32b burst: pulse exactly the cycle after DD
    PCLK = 2'b00;
    cyc(1, 8'hAA); cyc(1, 8'hBB); cyc(1, 8'hCC); cyc(1, 8'hDD);
    @(negedge clk);
    chk("w32_pulse", {31'b0, valid_out}, 32'h1);
    chk("w32_word", out_32, 32'hAABBCCDD);
    @(posedge clk); #1;
    chk("w32_single", {31'b0, valid_out}, 32'h0);
    e = '{32'hAABBCCDD}; chk_pulses("w32", e);

    // 16b with a two-cycle gap
    PCLK = 2'b01;
    cyc(1, 8'h12); cyc(0, 8'h00); cyc(0, 8'h00); cyc(1, 8'h34);
    cyc(0, 8'h00); cyc(0, 8'h00);
    e = '{32'h00001234}; chk_pulses("w16", e);

    // 8b streaming
    PCLK = 2'b10;
    cyc(1, 8'h01); cyc(1, 8'h02); cyc(1, 8'h03); cyc(0, 8'h00); cyc(0, 8'h00);
    e = '{32'h1, 32'h2, 32'h3}; chk_pulses("w8", e);

    // Mid-word width change is ignored until the word finishes
    PCLK = 2'b00;
    cyc(1, 8'h11); cyc(1, 8'h22);
    PCLK = 2'b10;
    cyc(1, 8'h33); cyc(1, 8'h44); cyc(1, 8'h55); cyc(0, 8'h00); cyc(0, 8'h00);
    e = '{32'h11223344, 32'h00000055}; chk_pulses("chg", e);

    // Abort with ENB low: partial word discarded, out_32 held
    PCLK = 2'b00;
    cyc(1, 8'hA1); cyc(1, 8'hA2);
    ENB = 1'b0; cyc(0, 8'h00);
    chk("abort_hold", out_32, 32'h00000055);
    ENB = 1'b1;
    cyc(1, 8'hB1); cyc(1, 8'hB2); cyc(1, 8'hB3); cyc(1, 8'hB4);
    cyc(0, 8'h00); cyc(0, 8'h00);
    e = '{32'hB1B2B3B4}; chk_pulses("abort", e);

    // Asynchronous reset between edges after two bytes
    cyc(1, 8'hC1); cyc(1, 8'hC2);
    #2 reset_L = 1'b0;
    #1;
    chk("arst_out", out_32, 32'h0);
    chk("arst_valid", {31'b0, valid_out}, 32'h0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    cyc(1, 8'hD1); cyc(1, 8'hD2); cyc(1, 8'hD3); cyc(1, 8'hD4);
    cyc(0, 8'h00); cyc(0, 8'h00);
    e = '{32'hD1D2D3D4}; chk_pulses("post_rst", e);

    // Reserved width packs as 8b
    PCLK = 2'b11;
    cyc(1, 8'h9C); cyc(0, 8'h00); cyc(0, 8'h00);
`ifdef CONVERTIDOR_ERR_EN
    chk("err_set", {31'b0, err}, 32'h1);
    PCLK = 2'b10;
    cyc(1, 8'h01);
    chk("err_sticky", {31'b0, err}, 32'h1);
    ENB = 1'b0; cyc(0, 8'h00);
    chk("err_clr", {31'b0, err}, 32'h0);
    ENB = 1'b1; cyc(0, 8'h00); cyc(0, 8'h00);
    e = '{32'h9C, 32'h01}; chk_pulses("rsv", e);
`else
    e = '{32'h0000009C}; chk_pulses("rsv", e);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
